iob_ila_reader: RTL

Hardware IOb-Native initiator that drains a captured trace out of an `iob_ila` instance without CPU involvement. On a start pulse it:
- reads the ILA's sample count;
- for each sample, writes the sample index and signal-select word, then reads the sample data;
- forwards each data word on a valid/ready stream toward a UART/DMA packer.

It sits where the CPU would normally sit on the ILA's IOb-Native port, typically behind a bus mux.

---
 rtl/iob_ila_reader_if.sv | 31 +++
 rtl/iob_ila_reader.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/iob_ila_reader_if.sv
// rtl/iob_ila_reader_if.sv - IOb-Native initiator bus and trace word stream seen from the reader
interface iob_ila_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic                iob_avalid_o;
  logic [ADDR_W-1:0]   iob_addr_o;
  logic [DATA_W-1:0]   iob_wdata_o;
  logic [DATA_W/8-1:0] iob_wstrb_o;
  logic                iob_ready_i;
  logic                iob_rvalid_i;
  logic [DATA_W-1:0]   iob_rdata_i;
  logic [DATA_W-1:0]   data_o;
  logic                data_valid_o;
  logic                data_ready_i;
  logic                data_last_o;

  modport master (
    output iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o,
    input  iob_ready_i, iob_rvalid_i, iob_rdata_i,
    output data_o, data_valid_o, data_last_o,
    input  data_ready_i
  );

  modport slave (
    input  iob_avalid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o,
    output iob_ready_i, iob_rvalid_i, iob_rdata_i,
    input  data_o, data_valid_o, data_last_o,
    output data_ready_i
  );
endinterface

// File: rtl/iob_ila_reader.sv
// rtl/iob_ila_reader.sv - drains an iob_ila trace over IOb-Native and streams the sample words
module iob_ila_reader #(
  parameter int               ADDR_W             = 16,
  parameter int               DATA_W             = 32,
  parameter int               SIGNAL_W           = 32,
  parameter int               BUFFER_W           = 10,
  parameter logic [ADDR_W-1:0] N_SAMPLES_ADDR     = 'h1C,
  parameter logic [ADDR_W-1:0] INDEX_ADDR         = 'h10,
  parameter logic [ADDR_W-1:0] SIGNAL_SELECT_ADDR = 'h14,
  parameter logic [ADDR_W-1:0] SAMPLE_DATA_ADDR   = 'h18
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              arst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [BUFFER_W:0] n_samples_o,
  iob_ila_reader_if.master  bus
);
  localparam int WORDS  = (SIGNAL_W + DATA_W - 1) / DATA_W;
  localparam int SEL_W  = $clog2(WORDS + 1);
  localparam int NS_W   = BUFFER_W + 1;
  localparam int STRB_W = DATA_W / 8;
  localparam int MAX_N  = 1 << BUFFER_W;

  typedef enum logic [3:0] {
    IDLE, RD_NS, WT_NS, WR_IDX, WR_SEL, RD_DAT, WT_DAT, OUT, DONE
  } state_t;

  state_t              state_q, state_d;
  logic [NS_W-1:0]     idx_q, idx_d, n_q, n_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   data_q, data_d, wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                avalid_q, avalid_d, dvalid_q, dvalid_d, dlast_q, dlast_d;
  logic                busy_q, busy_d, done_q, done_d;
  logic                accept;
  logic [31:0]         ns_raw;

  always_comb begin
    accept  = avalid_q & bus.iob_ready_i;
    ns_raw  = {16'd0, bus.iob_rdata_i[15:0]};
    state_d = state_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    n_d     = n_q;
    data_d  = data_q;

    unique case (state_q)
      IDLE:   if (start_i) state_d = RD_NS;
      RD_NS:  if (accept) state_d = WT_NS;
      WT_NS: begin
        if (bus.iob_rvalid_i) begin
          n_d = (ns_raw > 32'(MAX_N)) ? NS_W'(MAX_N) : NS_W'(ns_raw);
          if (n_d == '0) begin
            state_d = DONE;
          end else begin
            idx_d   = '0;
            sel_d   = '0;
            state_d = WR_IDX;
          end
        end
      end
      WR_IDX: if (accept) state_d = WR_SEL;
      WR_SEL: if (accept) state_d = RD_DAT;
      RD_DAT: if (accept) state_d = WT_DAT;
      WT_DAT: begin
        if (bus.iob_rvalid_i) begin
          data_d  = bus.iob_rdata_i;
          state_d = OUT;
        end
      end
      OUT: begin
        if (bus.data_ready_i) begin
          if (sel_q < SEL_W'(WORDS - 1)) begin
            sel_d   = sel_q + SEL_W'(1);
            state_d = WR_SEL;
          end else if (idx_q < n_q - NS_W'(1)) begin
            idx_d   = idx_q + NS_W'(1);
            sel_d   = '0;
            state_d = WR_IDX;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    avalid_d = 1'b0;
    addr_d   = '0;
    wdata_d  = '0;
    wstrb_d  = '0;
    unique case (state_d)
      RD_NS: begin
        avalid_d = 1'b1;
        addr_d   = N_SAMPLES_ADDR;
      end
      WR_IDX: begin
        avalid_d = 1'b1;
        addr_d   = INDEX_ADDR;
        wdata_d  = DATA_W'(idx_d);
        wstrb_d  = {STRB_W{1'b1}};
      end
      WR_SEL: begin
        avalid_d = 1'b1;
        addr_d   = SIGNAL_SELECT_ADDR;
        wdata_d  = DATA_W'(sel_d);
        wstrb_d  = {STRB_W{1'b1}};
      end
      RD_DAT: begin
        avalid_d = 1'b1;
        addr_d   = SAMPLE_DATA_ADDR;
      end
      default: ;
    endcase
    dvalid_d = (state_d == OUT);
    dlast_d  = dvalid_d && (idx_d == n_d - NS_W'(1)) && (sel_d == SEL_W'(WORDS - 1));
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
  end

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sel_q    <= '0;
      n_q      <= '0;
      data_q   <= '0;
      avalid_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      dvalid_q <= 1'b0;
      dlast_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (cke_i) begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sel_q    <= sel_d;
      n_q      <= n_d;
      data_q   <= data_d;
      avalid_q <= avalid_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      dvalid_q <= dvalid_d;
      dlast_q  <= dlast_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign n_samples_o      = n_q;
  assign bus.iob_avalid_o = avalid_q;
  assign bus.iob_addr_o   = addr_q;
  assign bus.iob_wdata_o  = wdata_q;
  assign bus.iob_wstrb_o  = wstrb_q;
  assign bus.data_o       = data_q;
  assign bus.data_valid_o = dvalid_q;
  assign bus.data_last_o  = dlast_q;
endmodule
